// File: rtl/wf_period_meter.sv
// wf_period_meter: counts time-base ticks between successive active edges of sig_in,
// with saturation, a no-edge timeout and a synchronous clear.
module wf_period_meter #(
  parameter int   WIDTH   = 16,
  parameter int   TIMEOUT = 1023,
  parameter logic EDGE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             sig_in,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             timeout,
  output logic             busy
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [WIDTH-1:0] TO  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t           state_q;
  logic             s1_q, s2_q, sp_q, ovf_pend_q;
  logic [WIDTH-1:0] cnt_q;
  logic             act_edge, to_hit;
  assign act_edge = EDGE ? (sp_q & ~s2_q) : (s2_q & ~sp_q);
  assign to_hit   = (TIMEOUT != 0) && (cnt_q == TO);
  assign busy     = state_q == MEASURE;
  // Synchronizer resets to the inactive level so a steady input never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q         <= ~EDGE;
      s2_q         <= ~EDGE;
      sp_q         <= ~EDGE;
      state_q      <= IDLE;
      cnt_q        <= '0;
      ovf_pend_q   <= 1'b0;
      period       <= '0;
      overflow     <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      s1_q         <= sig_in;
      s2_q         <= s1_q;
      sp_q         <= s2_q;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (clear) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        ovf_pend_q <= 1'b0;
        period     <= '0;
        overflow   <= 1'b0;
      end else if (act_edge) begin
        state_q    <= MEASURE;
        cnt_q      <= tick ? ONE : '0;
        ovf_pend_q <= 1'b0;
        if (state_q == MEASURE) begin
          period       <= cnt_q;
          overflow     <= ovf_pend_q;
          period_valid <= 1'b1;
        end
      end else if (state_q == MEASURE && tick) begin
        if (to_hit) begin
          timeout <= 1'b1;
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (&cnt_q) begin
          ovf_pend_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + ONE;
        end
      end
    end
  end
endmodule
